// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the frame-buffer RAM command path: data/address
// defaults and the command-scheduler state encoding.
package ram_port_arbiter_pkg;

    localparam int DATA_W_DEF = 768;
    localparam int ADDR_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WR_CMD = 2'd1,
        ST_RD_CMD = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ram_port_arbiter_wr_fifo.sv
// Synchronous FIFO with registered occupancy; DEPTH must be a power of two
// so the pointers wrap naturally.
module wr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign pop_ok  = pop_i && !empty_o;
    // A pop in the same cycle frees a slot, so a push while full still lands.
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        level_d  = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the frame-buffer RAM command port between buffered Ethernet writes
// and display reads; returned read data is registered once.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int HI_WM      = 3
) (
    input  logic                          clk125,
    input  logic                          reset,
    input  logic                          write_ram,
    input  logic [DATA_W-1:0]             write_data,
    input  logic [ADDR_W-1:0]             write_address,
    input  logic                          rd_req,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic                          rd_gnt,
    output logic                          rd_valid,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          mem_cmd_valid,
    input  logic                          mem_cmd_ready,
    output logic                          mem_cmd_we,
    output logic [ADDR_W-1:0]             mem_cmd_addr,
    output logic [DATA_W-1:0]             mem_wr_data,
    input  logic                          mem_rd_valid,
    input  logic [DATA_W-1:0]             mem_rd_data,
    output logic                          wr_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [1:0]                    dbg_state
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W = ADDR_W + DATA_W;

    arb_state_e        state_q, state_d;
    logic              forced_q, forced_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              cmd_we_q, cmd_we_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
    logic              rd_gnt_q, rd_gnt_d;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              wr_overflow_q;

    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ENT_W-1:0]  fifo_head;
    logic [LVL_W-1:0]  fifo_lvl;
    logic              rd_pending;
    logic              lvl_hi;

    wr_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk_i   (clk125),
        .rst_ni  (reset),
        .push_i  (write_ram),
        .pop_i   (fifo_pop),
        .wdata_i ({write_address, write_data}),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_lvl)
    );

    // The requester still holds rd_req during its rd_gnt cycle, so that
    // cycle must not be mistaken for a fresh request.
    assign rd_pending = rd_req && !rd_gnt_q;
    assign lvl_hi     = (fifo_lvl >= LVL_W'(HI_WM));

    // Memory command handshake: a command transfers on any cycle with
    // mem_cmd_valid && mem_cmd_ready; all fields are frozen while valid waits.
    always_comb begin
        state_d     = state_q;
        forced_d    = forced_q;
        cmd_valid_d = cmd_valid_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        rd_gnt_d    = 1'b0;
        fifo_pop    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (lvl_hi && !(forced_q && rd_pending)) begin
                    state_d     = ST_WR_CMD;
                    forced_d    = 1'b1;
                    cmd_valid_d = 1'b1;
                    cmd_we_d    = 1'b1;
                    cmd_addr_d  = fifo_head[ENT_W-1:DATA_W];
                    cmd_wdata_d = fifo_head[DATA_W-1:0];
                end else if (rd_pending) begin
                    state_d     = ST_RD_CMD;
                    forced_d    = 1'b0;
                    cmd_valid_d = 1'b1;
                    cmd_we_d    = 1'b0;
                    cmd_addr_d  = rd_addr;
                end else if (!fifo_empty) begin
                    state_d     = ST_WR_CMD;
                    forced_d    = 1'b0;
                    cmd_valid_d = 1'b1;
                    cmd_we_d    = 1'b1;
                    cmd_addr_d  = fifo_head[ENT_W-1:DATA_W];
                    cmd_wdata_d = fifo_head[DATA_W-1:0];
                end
            end
            ST_WR_CMD: begin
                if (mem_cmd_ready) begin
                    fifo_pop    = 1'b1;
                    cmd_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            ST_RD_CMD: begin
                if (mem_cmd_ready) begin
                    rd_gnt_d    = 1'b1;
                    cmd_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                cmd_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk125 or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            forced_q      <= 1'b0;
            cmd_valid_q   <= 1'b0;
            cmd_we_q      <= 1'b0;
            cmd_addr_q    <= '0;
            cmd_wdata_q   <= '0;
            rd_gnt_q      <= 1'b0;
            wr_overflow_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            forced_q      <= forced_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_we_q      <= cmd_we_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_wdata_q   <= cmd_wdata_d;
            rd_gnt_q      <= rd_gnt_d;
            wr_overflow_q <= wr_overflow_q | (write_ram && fifo_full && !fifo_pop);
        end
    end

    always_ff @(posedge clk125 or negedge reset) begin
        if (!reset) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= mem_rd_valid;
            rd_data_q  <= mem_rd_data;
        end
    end

    assign mem_cmd_valid = cmd_valid_q;
    assign mem_cmd_we    = cmd_we_q;
    assign mem_cmd_addr  = cmd_addr_q;
    assign mem_wr_data   = cmd_wdata_q;
    assign rd_gnt        = rd_gnt_q;
    assign rd_valid      = rd_valid_q;
    assign rd_data       = rd_data_q;
    assign wr_overflow   = wr_overflow_q;
    assign fifo_level    = fifo_lvl;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: command ordering, backpressure,
// overflow, read/write arbitration, read return and asynchronous reset.
module tb_ram_port_arbiter;

    localparam int DW = 768;
    localparam int AW = 32;
    localparam int LW = 41;

    logic          clk125;
    logic          reset;
    logic          write_ram;
    logic [DW-1:0] write_data;
    logic [AW-1:0] write_address;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_gnt;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          mem_cmd_valid;
    logic          mem_cmd_ready;
    logic          mem_cmd_we;
    logic [AW-1:0] mem_cmd_addr;
    logic [DW-1:0] mem_wr_data;
    logic          mem_rd_valid;
    logic [DW-1:0] mem_rd_data;
    logic          wr_overflow;
    logic [2:0]    fifo_level;
    logic [1:0]    dbg_state;

    int n_vec = 0;
    int n_err = 0;

    logic [LW-1:0] exp_q[$];
    logic [LW-1:0] log_q[$];

    ram_port_arbiter #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .FIFO_DEPTH (4),
        .HI_WM      (3)
    ) dut (
        .clk125        (clk125),
        .reset         (reset),
        .write_ram     (write_ram),
        .write_data    (write_data),
        .write_address (write_address),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_gnt        (rd_gnt),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .mem_cmd_valid (mem_cmd_valid),
        .mem_cmd_ready (mem_cmd_ready),
        .mem_cmd_we    (mem_cmd_we),
        .mem_cmd_addr  (mem_cmd_addr),
        .mem_wr_data   (mem_wr_data),
        .mem_rd_valid  (mem_rd_valid),
        .mem_rd_data   (mem_rd_data),
        .wr_overflow   (wr_overflow),
        .fifo_level    (fifo_level),
        .dbg_state     (dbg_state)
    );

    // clock / reset
    initial begin
        clk125 = 1'b0;
        forever #4 clk125 = ~clk125;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    // Every accepted command is logged as {we, addr, low data byte}.
    always @(negedge clk125) begin
        if (reset && mem_cmd_valid && mem_cmd_ready)
            log_q.push_back({mem_cmd_we, mem_cmd_addr, mem_cmd_we ? mem_wr_data[7:0] : 8'h00});
    end

    // driver / checker tasks
    task automatic tick();
        @(posedge clk125);
        #1;
    endtask

    task automatic check(input string tag, input logic [799:0] obs, input logic [799:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_drain(input int max_cyc);
        int n;
        n = 0;
        while ((fifo_level != 3'd0 || mem_cmd_valid) && n < max_cyc) begin
            tick();
            n++;
        end
        check("drain_idle", {fifo_level, mem_cmd_valid}, 800'd0);
    endtask

    task automatic wait_gnt(input int max_cyc);
        logic seen;
        int   n;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < max_cyc) begin
            tick();
            n++;
            seen = rd_gnt;
        end
        rd_req = 1'b0;
        check("rd_gnt_seen", seen, 1);
    endtask

    task automatic check_log();
        logic [LW-1:0] got;
        logic [LW-1:0] want;
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            if (log_q.size() > 0) got = log_q.pop_front();
            else got = 'x;
            check("cmd_order", got, want);
        end
        check("cmd_extra", log_q.size(), 0);
        log_q.delete();
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [7:0] b);
        write_ram     = 1'b1;
        write_address = a;
        write_data    = {96{b}};
    endtask

    initial begin
        reset = 1'b0; write_ram = 1'b0; write_data = '0; write_address = '0;
        rd_req = 1'b0; rd_addr = '0; mem_cmd_ready = 1'b0;
        mem_rd_valid = 1'b0; mem_rd_data = '0;
        repeat (3) @(posedge clk125);
        #1;
        check("rst_valid", mem_cmd_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ovf", wr_overflow, 0);
        check("rst_gnt", rd_gnt, 0);
        check("rst_rvalid", rd_valid, 0);
        check("rst_state", dbg_state, 0);
        reset = 1'b1;
        tick();

        // single write, ready tied high
        mem_cmd_ready = 1'b1;
        push_wr(32'h10, 8'hF3);
        tick();
        write_ram = 1'b0;
        check("t1_level_n1", fifo_level, 1);
        check("t1_valid_n1", mem_cmd_valid, 0);
        tick();
        check("t1_valid_n2", mem_cmd_valid, 1);
        check("t1_we", mem_cmd_we, 1);
        check("t1_addr", mem_cmd_addr, 32'h10);
        check("t1_data", mem_wr_data, {96{8'hF3}});
        check("t1_state", dbg_state, 1);
        exp_q.push_back({1'b1, 32'h10, 8'hF3});
        tick();
        check("t1_valid_n3", mem_cmd_valid, 0);
        check("t1_level_n3", fifo_level, 0);
        check_log();

        // backpressure for 10 cycles
        mem_cmd_ready = 1'b0;
        push_wr(32'h20, 8'h11);
        tick();
        write_ram = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("t2_hold_valid", mem_cmd_valid, 1);
            check("t2_hold_addr", mem_cmd_addr, 32'h20);
            check("t2_hold_data", mem_wr_data, {96{8'h11}});
            check("t2_hold_level", fifo_level, 1);
            tick();
        end
        mem_cmd_ready = 1'b1;
        tick();
        check("t2_valid_after", mem_cmd_valid, 0);
        check("t2_level_after", fifo_level, 0);
        tick();
        tick();
        exp_q.push_back({1'b1, 32'h20, 8'h11});
        check_log();

        // overflow: five back-to-back strobes, memory stalled
        mem_cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_wr(32'(32'h100 + 4 * i), 8'(8'h30 + i));
            tick();
            if (i == 3) begin
                check("t3_level_4th", fifo_level, 4);
                check("t3_ovf_4th", wr_overflow, 0);
            end
        end
        write_ram = 1'b0;
        check("t3_level_5th", fifo_level, 4);
        check("t3_ovf_5th", wr_overflow, 1);
        mem_cmd_ready = 1'b1;
        wait_drain(40);
        for (int i = 0; i < 4; i++)
            exp_q.push_back({1'b1, 32'(32'h100 + 4 * i), 8'(8'h30 + i)});
        check_log();
        check("t3_ovf_sticky", wr_overflow, 1);

        // read wins over a low-level write
        push_wr(32'h300, 8'h44);
        tick();
        write_ram = 1'b0;
        rd_req    = 1'b1;
        rd_addr   = 32'h200;
        tick();
        check("t4a_rd_valid", mem_cmd_valid, 1);
        check("t4a_rd_we", mem_cmd_we, 0);
        check("t4a_rd_addr", mem_cmd_addr, 32'h200);
        check("t4a_rd_state", dbg_state, 2);
        tick();
        check("t4a_gnt", rd_gnt, 1);
        rd_req = 1'b0;
        tick();
        check("t4a_gnt_pulse", rd_gnt, 0);
        check("t4a_wr_addr", mem_cmd_addr, 32'h300);
        wait_drain(20);
        exp_q.push_back({1'b0, 32'h200, 8'h00});
        exp_q.push_back({1'b1, 32'h300, 8'h44});
        check_log();

        // watermark: one forced write, then the read even at level 3
        mem_cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_wr(32'(32'h400 + 4 * i), 8'(8'h50 + i));
            tick();
        end
        write_ram = 1'b0;
        check("t4b_level_full", fifo_level, 4);
        check("t4b_head_addr", mem_cmd_addr, 32'h400);
        rd_req        = 1'b1;
        rd_addr       = 32'h200;
        mem_cmd_ready = 1'b1;
        tick();
        check("t4b_level_pop", fifo_level, 3);
        push_wr(32'h410, 8'h54);
        tick();
        write_ram = 1'b0;
        check("t4b_level_refill", fifo_level, 4);
        wait_gnt(20);
        wait_drain(40);
        exp_q.push_back({1'b1, 32'h400, 8'h50});
        exp_q.push_back({1'b1, 32'h404, 8'h51});
        exp_q.push_back({1'b0, 32'h200, 8'h00});
        exp_q.push_back({1'b1, 32'h408, 8'h52});
        exp_q.push_back({1'b1, 32'h40C, 8'h53});
        exp_q.push_back({1'b1, 32'h410, 8'h54});
        check_log();

        // read return path
        mem_rd_valid = 1'b1;
        mem_rd_data  = {96{8'hA5}};
        check("t5_rv_same_cycle", rd_valid, 0);
        tick();
        check("t5_rv_1", rd_valid, 1);
        check("t5_rd_1", rd_data, {96{8'hA5}});
        mem_rd_data = {96{8'h5A}};
        tick();
        check("t5_rv_2", rd_valid, 1);
        check("t5_rd_2", rd_data, {96{8'h5A}});
        mem_rd_valid = 1'b0;
        tick();
        check("t5_rv_end", rd_valid, 0);

        // asynchronous reset while a write command is stalled
        mem_cmd_ready = 1'b0;
        push_wr(32'h500, 8'h66);
        tick();
        write_ram = 1'b0;
        tick();
        check("t6_valid_pre", mem_cmd_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_valid", mem_cmd_valid, 0);
        check("t6_we", mem_cmd_we, 0);
        check("t6_addr", mem_cmd_addr, 0);
        check("t6_data", mem_wr_data, 0);
        check("t6_level", fifo_level, 0);
        check("t6_ovf", wr_overflow, 0);
        check("t6_rd_data", rd_data, 0);
        check("t6_state", dbg_state, 0);
        #2;
        reset = 1'b1;
        mem_cmd_ready = 1'b1;
        tick();
        check("t6_level_post", fifo_level, 0);
        check("t6_ovf_post", wr_overflow, 0);
        tick();
        check("t6_valid_post", mem_cmd_valid, 0);
        check_log();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single frame-buffer RAM command port between two requesters: the Ethernet screen-packet write path and the display read requester.
- The write path issues single-cycle write strobes (768-bit word plus 32-bit address) and has no backpressure, so the block buffers those writes in a small FIFO.
- The block then schedules buffered writes and pending reads onto a valid/ready memory command port.
- Read data returned by the memory is registered once and forwarded to the display side.

Parameters:
- DATA_W, 768, write/read data width in bits (96 bytes)
- ADDR_W, 32, address width
- FIFO_DEPTH, 4, write-buffer entries; power of two, minimum 2
- HI_WM, 3, write-FIFO level at or above which writes take priority over reads; range 1..FIFO_DEPTH

Ports:
- clk125  in  1  system clock, 125 MHz
- reset  in  1  asynchronous, active-low reset
- write_ram  in  1  one-cycle write strobe from the Ethernet path
- write_data  in  DATA_W  write word, qualified by write_ram
- write_address  in  ADDR_W  write address, qualified by write_ram
- rd_req  in  1  display read request, held high until rd_gnt
- rd_addr  in  ADDR_W  read address, stable while rd_req is high
- rd_gnt  out  1  one-cycle pulse: read command accepted by memory
- rd_valid  out  1  read data valid (one cycle per word)
- rd_data  out  DATA_W  read data
- mem_cmd_valid  out  1  command valid
- mem_cmd_ready  in  1  memory accepts the command when valid && ready
- mem_cmd_we  out  1  1 = write, 0 = read
- mem_cmd_addr  out  ADDR_W  command address
- mem_wr_data  out  DATA_W  write data, valid with a write command
- mem_rd_valid  in  1  returned read data valid
- mem_rd_data  in  DATA_W  returned read data
- wr_overflow  out  1  sticky: a write strobe was dropped
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current write-FIFO occupancy

Behaviour:
- Reset (reset=0, asynchronous): FIFO is emptied, FSM goes to IDLE, all outputs are 0.
- Write FIFO:
  - write_ram=1 pushes {write_address, write_data} at the clock edge.
  - If the FIFO is full and no pop occurs in that cycle, the strobe is dropped and wr_overflow is set. wr_overflow clears only on reset.
  - Push and pop in the same cycle while full: the push is accepted and the level is unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH. fifo_level is registered.
- FSM states: IDLE, WR_CMD, RD_CMD.
  - IDLE: arbitrate on the registered FIFO level and on rd_req.
    - If level >= HI_WM, go to WR_CMD.
    - Else if rd_req, go to RD_CMD.
    - Else if level > 0, go to WR_CMD.
    - Else stay in IDLE.
    - On entry to either command state, the head entry (or rd_addr) is latched into the mem_cmd_* registers and mem_cmd_valid=1.
  - WR_CMD: hold mem_cmd_valid=1, mem_cmd_we=1, address and data stable until mem_cmd_ready=1. On that cycle, pop the FIFO and return to IDLE.
  - RD_CMD: hold mem_cmd_valid=1, mem_cmd_we=0 until mem_cmd_ready=1. On that cycle, pulse rd_gnt=1 (registered, so it is high in the following cycle) and return to IDLE.
  - Command fields never change while mem_cmd_valid=1 and mem_cmd_ready=0.
- Fairness: after a write is granted through the HI_WM override, the next IDLE decision gives a pending read priority, even if level is still >= HI_WM. This prevents read starvation; at most one forced write occurs between reads.
- Latency:
  - write_ram in cycle n gives FIFO level 1 in n+1. If the FSM is in IDLE at n+1, mem_cmd_valid=1 in n+2.
  - Minimum one IDLE cycle between commands, so throughput is 1 command per 2 cycles. The Ethernet path produces at most 1 word per 96 cycles, so this is sufficient.
- Read return: rd_valid and rd_data are mem_rd_valid and mem_rd_data registered once (1-cycle latency, order preserved). They are independent of the FSM, and returns may overlap a write command.
- Reset mid-command: the command is abandoned, and buffered writes are discarded.

Decomposition:
- Shared package: the FSM state encoding (IDLE, WR_CMD, RD_CMD) and the DATA_W/ADDR_W defaults, common with the Ethernet-to-RAM path.
- One sub-module, wr_fifo: synchronous FIFO, parameterized width and depth, with full, empty, and level outputs.

Test Plan:
- Single write: after reset, one write_ram with addr 0x00000010 and data {96{8'hF3}}, mem_cmd_ready tied to 1 → mem_cmd_valid=1 exactly 2 cycles later, with we=1, addr 0x10, data matching; fifo_level returns to 0.
- Backpressure: mem_cmd_ready=0 for 10 cycles with one write queued → command fields are held stable for all 10 cycles, pop occurs only on the ready cycle, no duplicate command.
- Overflow: 5 write strobes in consecutive cycles with mem_cmd_ready=0, FIFO_DEPTH=4 → fifo_level=4, wr_overflow=1 after the 5th strobe, the 5th entry is never issued, and the first 4 drain in order.
- Read priority and watermark: rd_req with rd_addr 0x200 while level=1 → read issues first and rd_gnt pulses. Repeat with level=3 → one write issues, then the read, then the remaining writes.
- Read return: mem_rd_valid pulse with data 0xA5.. → rd_valid and rd_data appear exactly 1 cycle later.
- Async reset: assert reset=0 mid-WR_CMD, between clock edges → all outputs are 0 immediately; after release, fifo_level=0 and wr_overflow=0.
